// File: rtl/flappy_pkg.sv
// Shared definitions for the flappy-bird datapath: life-cycle state encodings,
// screen geometry and velocity/arithmetic widths.
package flappy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_FLYING = 2'b01,
    ST_DEAD   = 2'b10
  } bird_state_t;

  localparam int SCREEN_H    = 480;
  localparam int FLOOR_Y_DEF = 440;
  localparam int BIRD_H_DEF  = 20;

  localparam int VEL_W  = 10;
  localparam int POS_W  = 10;
  // Integration width: wide enough that bird_y - (velocity >>> shift) never wraps.
  localparam int CALC_W = 12;

endpackage

// File: rtl/button_sync.sv
// Two-flop synchronizer for a raw asynchronous button, followed by a rising-edge
// detector that yields a single-cycle btn_edge pulse in the clk domain.
module button_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_async,
  output logic btn_edge
);

  logic sync_p0;
  logic sync_p1;
  logic sync_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      sync_p0 <= btn_async;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  // Edge is taken only from the metastability-safe stages.
  assign btn_edge = sync_p1 & ~sync_p2;

endmodule

// File: rtl/bird_position.sv
// Integrates bird velocity into a screen row and runs the IDLE/FLYING/DEAD FSM.
// Define BIRD_CEILING_KILL_EN to make ceiling contact fatal like a floor hit.
module bird_position
  import flappy_pkg::*;
#(
  parameter int START_Y   = 240,
  parameter int FLOOR_Y   = FLOOR_Y_DEF,
  parameter int CEIL_Y    = 0,
  parameter int BIRD_H    = BIRD_H_DEF,
  parameter int VEL_SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [VEL_W-1:0] velocity,
  input  logic             vel_strobe,
  input  logic             flap_button,
  input  logic             restart,
  output logic [POS_W-1:0] bird_y,
  output logic [1:0]       state,
  output logic             pos_valid,
  output logic             game_over
);

  localparam logic [POS_W-1:0]         START_ROW = POS_W'(START_Y);
  localparam logic signed [CALC_W-1:0] FLOOR_LIM = CALC_W'(FLOOR_Y - BIRD_H);
  localparam logic signed [CALC_W-1:0] CEIL_LIM  = CALC_W'(CEIL_Y);

`ifdef BIRD_CEILING_KILL_EN
  localparam bit CEIL_KILL = 1'b1;
`else
  localparam bit CEIL_KILL = 1'b0;
`endif

  // Arithmetic shift floors toward minus infinity (-10 -> -3).
  function automatic logic signed [CALC_W-1:0] scale_velocity(input logic [VEL_W-1:0] v);
    logic signed [CALC_W-1:0] ext;
    ext = {{(CALC_W-VEL_W){v[VEL_W-1]}}, v};
    return ext >>> VEL_SHIFT;
  endfunction

  // Saturate to the legal sprite rows before truncating to the output width.
  function automatic logic [POS_W-1:0] clamp_position(input logic signed [CALC_W-1:0] p);
    if (p >= FLOOR_LIM)
      return FLOOR_LIM[POS_W-1:0];
    else if (p < CEIL_LIM)
      return CEIL_LIM[POS_W-1:0];
    else
      return p[POS_W-1:0];
  endfunction

  logic                     flap_edge;
  bird_state_t              st_q;
  logic signed [CALC_W-1:0] delta_p0;
  logic signed [CALC_W-1:0] next_p0;
  logic [POS_W-1:0]         clamp_y_p0;
  logic                     floor_hit_p0;
  logic                     ceil_hit_p0;
  logic                     kill_p0;

  button_sync u_flap_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_async(flap_button),
    .btn_edge (flap_edge)
  );

  // Stage p0: combinational integration step on the current row.
  always_comb begin
    delta_p0     = scale_velocity(velocity);
    next_p0      = $signed({{(CALC_W-POS_W){1'b0}}, bird_y}) - delta_p0;
    floor_hit_p0 = (next_p0 >= FLOOR_LIM);
    ceil_hit_p0  = (next_p0 < CEIL_LIM);
    kill_p0      = floor_hit_p0 | (CEIL_KILL & ceil_hit_p0);
    clamp_y_p0   = clamp_position(next_p0);
  end

  // Stage p1: registered position, FSM state and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bird_y    <= START_ROW;
      st_q      <= ST_IDLE;
      pos_valid <= 1'b0;
      game_over <= 1'b0;
    end else if (restart) begin
      bird_y    <= START_ROW;
      st_q      <= ST_IDLE;
      pos_valid <= 1'b0;
      game_over <= 1'b0;
    end else begin
      case (st_q)
        ST_IDLE: begin
          pos_valid <= 1'b0;
          game_over <= 1'b0;
          if (flap_edge)
            st_q <= ST_FLYING;
        end
        ST_FLYING: begin
          pos_valid <= vel_strobe;
          if (vel_strobe) begin
            bird_y <= clamp_y_p0;
            if (kill_p0) begin
              st_q      <= ST_DEAD;
              game_over <= 1'b1;
            end
          end
        end
        ST_DEAD: begin
          pos_valid <= 1'b0;
          game_over <= 1'b1;
        end
        default: begin
          st_q      <= ST_IDLE;
          pos_valid <= 1'b0;
          game_over <= 1'b0;
        end
      endcase
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_bird_position.sv
// Self-checking bench for bird_position: vector table with a scoreboard queue,
// plus hand-written sequences for reset, DEAD hold, restart and flap/strobe races.
module tb_bird_position;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] velocity = '0;
  logic       vel_strobe = 1'b0;
  logic       flap_button = 1'b0;
  logic       restart = 1'b0;
  logic [9:0] bird_y;
  logic [1:0] state;
  logic       pos_valid;
  logic       game_over;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int vel;
    int exp_y;
    int exp_st;
  } vec_t;

  typedef struct {
    int y;
    int st;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  bird_position dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .velocity   (velocity),
    .vel_strobe (vel_strobe),
    .flap_button(flap_button),
    .restart    (restart),
    .bird_y     (bird_y),
    .state      (state),
    .pos_valid  (pos_valid),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_flying();
    bit seen;
    flap_button = 1'b0;
    repeat (4) @(negedge clk);
    flap_button = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (state == 2'b01) seen = 1'b1;
    end
    chk("start_flying_state", int'(state), 1);
  endtask

  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    exp_t e;
    exp_t got;
    bit   seen;
    @(negedge clk);
    velocity   = 10'(v.vel);
    vel_strobe = 1'b1;
    e.y  = v.exp_y;
    e.st = v.exp_st;
    sb.push_back(e);
    @(negedge clk);
    vel_strobe = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      if (pos_valid) seen = 1'b1;
      else @(negedge clk);
    end
    got = sb.pop_front();
    if (!seen) begin
      chk("pos_valid_timeout", 0, 1);
    end else begin
      chk($sformatf("bird_y vel=%0d", v.vel), int'(bird_y), got.y);
      chk($sformatf("state vel=%0d", v.vel), int'(state), got.st);
      chk($sformatf("game_over vel=%0d", v.vel), int'(game_over), (got.st == 2) ? 1 : 0);
      @(negedge clk);
      chk("pos_valid_one_cycle", int'(pos_valid), 0);
    end
  endtask

  initial begin
    int pv_seen;
    int idx;

    // Run A: climb, rounding cases, then descend onto the floor.
    vecs.push_back('{40, 230, 1});
    vecs.push_back('{3, 230, 1});
    vecs.push_back('{-10, 233, 1});
    vecs.push_back('{-512, 361, 1});
    vecs.push_back('{-228, 418, 1});
    vecs.push_back('{-40, 420, 2});
    // Run B: climb into the ceiling.
    vecs.push_back('{511, 113, 1});
    vecs.push_back('{432, 5, 1});
`ifdef BIRD_CEILING_KILL_EN
    vecs.push_back('{40, 0, 2});
`else
    vecs.push_back('{40, 0, 1});
    vecs.push_back('{-1, 1, 1});
`endif

    repeat (3) @(negedge clk);
    chk("reset_bird_y", int'(bird_y), 240);
    chk("reset_state", int'(state), 0);
    chk("reset_pos_valid", int'(pos_valid), 0);
    chk("reset_game_over", int'(game_over), 0);
    rst_n = 1'b1;

    @(negedge clk);
    velocity   = 10'd40;
    vel_strobe = 1'b1;
    @(negedge clk);
    vel_strobe = 1'b0;
    chk("idle_strobe_pos_valid", int'(pos_valid), 0);
    chk("idle_strobe_bird_y", int'(bird_y), 240);
    chk("idle_strobe_state", int'(state), 0);

    start_flying();
    chk("start_bird_y", int'(bird_y), 240);

    for (idx = 0; idx < 6; idx++) apply_vec(vecs[idx]);

    // DEAD must ignore strobes and flaps.
    pv_seen = 0;
    flap_button = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      velocity   = 10'h3D8;
      vel_strobe = 1'b1;
      @(negedge clk);
      vel_strobe = 1'b0;
      if (pos_valid) pv_seen++;
    end
    flap_button = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (pos_valid) pv_seen++;
    end
    chk("dead_pos_valid_count", pv_seen, 0);
    chk("dead_bird_y", int'(bird_y), 420);
    chk("dead_state", int'(state), 2);
    chk("dead_game_over", int'(game_over), 1);

    do_restart();
    chk("restart_bird_y", int'(bird_y), 240);
    chk("restart_state", int'(state), 0);
    chk("restart_game_over", int'(game_over), 0);

    start_flying();
    for (idx = 6; idx < vecs.size(); idx++) apply_vec(vecs[idx]);

    // restart wins over a same-cycle vel_strobe.
    do_restart();
    start_flying();
    apply_vec('{-240, 300, 1});
    @(negedge clk);
    restart    = 1'b1;
    vel_strobe = 1'b1;
    velocity   = 10'd40;
    @(negedge clk);
    restart    = 1'b0;
    vel_strobe = 1'b0;
    chk("restart_race_bird_y", int'(bird_y), 240);
    chk("restart_race_state", int'(state), 0);
    chk("restart_race_pos_valid", int'(pos_valid), 0);

    // Flap edge and strobe in the same IDLE cycle: enter FLYING, no integration.
    flap_button = 1'b0;
    repeat (4) @(negedge clk);
    flap_button = 1'b1;
    @(negedge clk);
    @(negedge clk);
    velocity   = 10'd40;
    vel_strobe = 1'b1;
    @(negedge clk);
    vel_strobe = 1'b0;
    chk("flap_race_state", int'(state), 1);
    chk("flap_race_bird_y", int'(bird_y), 240);
    chk("flap_race_pos_valid", int'(pos_valid), 0);

    apply_vec('{40, 230, 1});

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_bird_y", int'(bird_y), 240);
    chk("async_rst_state", int'(state), 0);
    chk("async_rst_pos_valid", int'(pos_valid), 0);
    chk("async_rst_game_over", int'(game_over), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
